// File: rtl/core_control_operand_seq.sv
// Operand sequencer: drives ALU/shifter operands through issue, shift, multi-beat transfer and exception cycles.
// Accepts one instruction per sequence (issue_ready only in IDLE); TRANSFER stalls on mem_ready, exc_req aborts it.
module core_control_operand_seq #(
    parameter int         WORD_W     = 32,
    parameter int         IMM_W      = 12,
    parameter int         SHAMT_W    = 8,
    parameter int         MAX_BEATS  = 16,
    parameter int         EXC_OFFSET = 4,
    parameter logic [3:0] ALU_ADD    = 4'b0100,
    parameter int         BEAT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [3:0]          dec_op,
    input  logic                dec_is_imm,
    input  logic                dec_shift_by_reg,
    input  logic                dec_has_shift,
    input  logic [IMM_W-1:0]    dec_imm,
    input  logic [SHAMT_W-1:0]  dec_shift_imm,
    input  logic                dec_shr,
    input  logic                dec_ror,
    input  logic                dec_put_carry,
    input  logic                dec_sign_extend,
    input  logic [BEAT_W-1:0]   dec_beats,
    input  logic [WORD_W-1:0]   dec_step,
    input  logic                flags_c,
    input  logic [WORD_W-1:0]   rd_value_a,
    input  logic [WORD_W-1:0]   rd_value_b,
    input  logic [WORD_W-1:0]   q_alu,
    input  logic [WORD_W-1:0]   q_shifter,
    input  logic                c_shifter,
    input  logic                mem_ready,
    input  logic                exc_req,
    input  logic [WORD_W-3:0]   pc,
    output logic [2:0]          cycle,
    output logic [3:0]          alu_op,
    output logic [WORD_W-1:0]   alu_a,
    output logic [WORD_W-1:0]   alu_b,
    output logic [WORD_W-1:0]   saved_base,
    output logic [SHAMT_W-1:0]  shifter_shift,
    output logic                shr,
    output logic                ror,
    output logic                put_carry,
    output logic                sign_extend,
    output logic                c_in,
    output logic                trivial_shift,
    output logic [BEAT_W-1:0]   beats_left,
    output logic                done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_RD_SHIFT = 3'd2;
    localparam logic [2:0] S_WITH_SH  = 3'd3;
    localparam logic [2:0] S_TRANSFER = 3'd4;
    localparam logic [2:0] S_EXC      = 3'd5;

    localparam logic [WORD_W-1:0] EXC_OFF = WORD_W'(EXC_OFFSET);

    logic [2:0]         state_q, state_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic               is_imm_q, is_imm_d;
    logic               shift_by_reg_q, shift_by_reg_d;
    logic               has_shift_q, has_shift_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic [SHAMT_W-1:0] shift_imm_q, shift_imm_d;
    logic               shr_q, shr_d;
    logic               ror_q, ror_d;
    logic               put_carry_q, put_carry_d;
    logic               sign_extend_q, sign_extend_d;
    logic [BEAT_W-1:0]  beats_q, beats_d;
    logic [WORD_W-1:0]  step_q, step_d;
    logic               c_in_q, c_in_d;
    logic [WORD_W-1:0]  saved_base_q, saved_base_d;
    logic [BEAT_W-1:0]  beats_left_q, beats_left_d;

    logic [WORD_W-1:0]  imm_ext;
    logic               last_beat;

    assign imm_ext   = {{(WORD_W-IMM_W){1'b0}}, imm_q};
    assign last_beat = (beats_left_q == BEAT_W'(1));

    // Next-state and register updates
    always_comb begin
        state_d        = state_q;
        alu_op_d       = alu_op_q;
        is_imm_d       = is_imm_q;
        shift_by_reg_d = shift_by_reg_q;
        has_shift_d    = has_shift_q;
        imm_d          = imm_q;
        shift_imm_d    = shift_imm_q;
        shr_d          = shr_q;
        ror_d          = ror_q;
        put_carry_d    = put_carry_q;
        sign_extend_d  = sign_extend_q;
        beats_d        = beats_q;
        step_d         = step_q;
        c_in_d         = c_in_q;
        saved_base_d   = saved_base_q;
        beats_left_d   = beats_left_q;

        case (state_q)
            S_IDLE: begin
                if (exc_req) begin
                    state_d  = S_EXC;
                    alu_op_d = ALU_ADD;
                end else if (issue_valid) begin
                    state_d        = S_ISSUE;
                    alu_op_d       = dec_op;
                    is_imm_d       = dec_is_imm;
                    shift_by_reg_d = dec_shift_by_reg;
                    has_shift_d    = dec_has_shift;
                    imm_d          = dec_imm;
                    shift_imm_d    = dec_shift_imm;
                    shr_d          = dec_shr;
                    ror_d          = dec_ror;
                    put_carry_d    = dec_put_carry;
                    sign_extend_d  = dec_sign_extend;
                    beats_d        = dec_beats;
                    step_d         = dec_step;
                    c_in_d         = flags_c;
                end
            end
            S_ISSUE: begin
                if (shift_by_reg_q) begin
                    // Park operand B while the next cycle reads the shift-amount register
                    state_d        = S_RD_SHIFT;
                    saved_base_d   = rd_value_b;
                    shift_by_reg_d = 1'b0;
                end else if (has_shift_q) begin
                    state_d      = S_WITH_SH;
                    saved_base_d = q_shifter;
                    c_in_d       = c_shifter;
                end else if (beats_q != '0) begin
                    state_d      = S_TRANSFER;
                    saved_base_d = q_alu;
                    alu_op_d     = ALU_ADD;
                    beats_left_d = beats_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_SHIFT: begin
                state_d      = S_WITH_SH;
                saved_base_d = q_shifter;
                c_in_d       = c_shifter;
            end
            S_WITH_SH: begin
                if (beats_q != '0) begin
                    state_d      = S_TRANSFER;
                    saved_base_d = q_alu;
                    alu_op_d     = ALU_ADD;
                    beats_left_d = beats_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TRANSFER: begin
                // Data abort wins over a completing beat; the address is left as it was
                if (exc_req) begin
                    state_d      = S_EXC;
                    alu_op_d     = ALU_ADD;
                    beats_left_d = '0;
                end else if (mem_ready) begin
                    saved_base_d = q_alu;
                    beats_left_d = beats_left_q - BEAT_W'(1);
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_EXC: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            alu_op_q       <= '0;
            is_imm_q       <= 1'b0;
            shift_by_reg_q <= 1'b0;
            has_shift_q    <= 1'b0;
            imm_q          <= '0;
            shift_imm_q    <= '0;
            shr_q          <= 1'b0;
            ror_q          <= 1'b0;
            put_carry_q    <= 1'b0;
            sign_extend_q  <= 1'b0;
            beats_q        <= '0;
            step_q         <= '0;
            c_in_q         <= 1'b0;
            saved_base_q   <= '0;
            beats_left_q   <= '0;
        end else begin
            state_q        <= state_d;
            alu_op_q       <= alu_op_d;
            is_imm_q       <= is_imm_d;
            shift_by_reg_q <= shift_by_reg_d;
            has_shift_q    <= has_shift_d;
            imm_q          <= imm_d;
            shift_imm_q    <= shift_imm_d;
            shr_q          <= shr_d;
            ror_q          <= ror_d;
            put_carry_q    <= put_carry_d;
            sign_extend_q  <= sign_extend_d;
            beats_q        <= beats_d;
            step_q         <= step_d;
            c_in_q         <= c_in_d;
            saved_base_q   <= saved_base_d;
            beats_left_q   <= beats_left_d;
        end
    end

    // Operand muxing per sequencing cycle
    always_comb begin
        alu_a         = rd_value_a;
        alu_b         = rd_value_b;
        shifter_shift = shift_imm_q;
        case (state_q)
            S_ISSUE: begin
                alu_b = is_imm_q ? imm_ext : rd_value_b;
            end
            S_RD_SHIFT: begin
                alu_b         = saved_base_q;
                shifter_shift = rd_value_b[SHAMT_W-1:0];
            end
            S_WITH_SH: begin
                alu_b = saved_base_q;
            end
            S_TRANSFER: begin
                alu_a = saved_base_q;
                alu_b = step_q;
            end
            S_EXC: begin
                alu_a = {pc, 2'b00};
                alu_b = EXC_OFF;
            end
            default: begin
                alu_a = rd_value_a;
            end
        endcase
    end

    always_comb begin
        done = 1'b0;
        case (state_q)
            S_ISSUE:    done = !shift_by_reg_q && !has_shift_q && (beats_q == '0);
            S_WITH_SH:  done = (beats_q == '0);
            S_TRANSFER: done = !exc_req && mem_ready && last_beat;
            S_EXC:      done = 1'b1;
            default:    done = 1'b0;
        endcase
    end

    assign issue_ready   = (state_q == S_IDLE);
    assign trivial_shift = (shifter_shift == '0);
    assign cycle         = state_q;
    assign alu_op        = alu_op_q;
    assign saved_base    = saved_base_q;
    assign shr           = shr_q;
    assign ror           = ror_q;
    assign put_carry     = put_carry_q;
    assign sign_extend   = sign_extend_q;
    assign c_in          = c_in_q;
    assign beats_left    = beats_left_q;

endmodule

// File: doc/core_control_operand_seq.md
# core_control_operand_seq

Parametrised operand sequencer for the core's data path. It latches one decoded data-processing or transfer instruction and steps through issue, indirect shift, immediate shift, multi-beat transfer and exception-entry cycles. In each cycle it drives the ALU and shifter operands and controls. It sits between decode/register-file read and the ALU/shifter. Compared with the single-transfer version, it adds configurable width, multi-beat transfers with a stepping offset, and data-abort preemption.

## Interface
Parameters:
- WORD_W, 32, data word width; pc is WORD_W-2 bits.
- IMM_W, 12, immediate operand width; zero-extended to WORD_W.
- SHAMT_W, 8, shift-amount width.
- MAX_BEATS, 16, maximum transfer beats; BEAT_W = clog2(MAX_BEATS+1).
- EXC_OFFSET, 4, constant added to {pc,2'b00} on exception entry.
- ALU_ADD, 4'b0100, ALU opcode for add.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decoded instruction presented.
- issue_ready  out  1  high exactly when in IDLE.
- dec_op  in  4  ALU opcode.
- dec_is_imm  in  1  second operand is the immediate.
- dec_shift_by_reg  in  1  shift amount comes from a register.
- dec_has_shift  in  1  immediate shift stage is required.
- dec_imm  in  IMM_W  immediate operand.
- dec_shift_imm  in  SHAMT_W  immediate shift amount.
- dec_shr, dec_ror, dec_put_carry, dec_sign_extend  in  1 each  shifter mode bits.
- dec_beats  in  BEAT_W  transfer beat count; 0 means no transfer.
- dec_step  in  WORD_W  per-beat address step.
- flags_c  in  1  architectural carry flag.
- rd_value_a, rd_value_b  in  WORD_W  register-file read ports.
- q_alu, q_shifter  in  WORD_W  ALU and shifter results.
- c_shifter  in  1  shifter carry-out.
- mem_ready  in  1  current transfer beat has completed.
- exc_req  in  1  exception request; a data abort when raised in TRANSFER.
- pc  in  WORD_W-2  current word address.
- cycle  out  3  state: IDLE=0, ISSUE=1, RD_INDIRECT_SHIFT=2, WITH_SHIFT=3, TRANSFER=4, EXCEPTION=5.
- alu_op  out  4  ALU opcode.
- alu_a, alu_b  out  WORD_W  ALU operands (combinational).
- saved_base  out  WORD_W  internal operand/address register.
- shifter_shift  out  SHAMT_W  shift amount (combinational).
- shr, ror, put_carry, sign_extend  out  1 each  latched shifter controls.
- c_in  out  1  carry input to the ALU.
- trivial_shift  out  1  high when shifter_shift == 0.
- beats_left  out  BEAT_W  remaining transfer beats.
- done  out  1  high in the final cycle of a sequence.

## Operation
- Reset: state IDLE; all registered outputs, latched fields and beats_left are 0; done=0; issue_ready=1.

IDLE:
- If exc_req is high, go to EXCEPTION. This takes priority over issue_valid.
- Otherwise, if issue_valid is high, latch all dec_* fields and c_in<=flags_c, then go to ISSUE.

ISSUE:
- alu_a=rd_value_a.
- alu_b={0,dec_imm} if is_imm, else rd_value_b.
- shifter_shift=shift_imm.
- Next state:
  - shift_by_reg: go to RD_INDIRECT_SHIFT; saved_base<=rd_value_b; clear shift_by_reg.
  - Else has_shift: go to WITH_SHIFT; saved_base<=q_shifter; c_in<=c_shifter.
  - Else beats≠0: go to TRANSFER.
  - Else done: go to IDLE.

RD_INDIRECT_SHIFT:
- shifter_shift=rd_value_b[SHAMT_W-1:0].
- alu_b=saved_base.
- Then go to WITH_SHIFT, capturing saved_base<=q_shifter and c_in<=c_shifter.

WITH_SHIFT:
- alu_a=rd_value_a; alu_b=saved_base.
- Then go to TRANSFER if beats≠0, else done and go to IDLE.

TRANSFER:
- On entry: saved_base<=q_alu, alu_op<=ALU_ADD, beats_left<=dec_beats.
- Each cycle: alu_a=saved_base, alu_b=step.
- On mem_ready: saved_base<=q_alu and beats_left decrements. When beats_left==1, done is high and the next state is IDLE.
- mem_ready low: hold every register.

EXCEPTION:
- On entry: alu_op<=ALU_ADD.
- alu_a={pc,2'b00}; alu_b=EXC_OFFSET.
- One cycle with done high, then go to IDLE.

Other rules:
- Abort: exc_req in TRANSFER preempts mem_ready. Remaining beats are dropped, beats_left<=0, saved_base is unchanged, and the next state is EXCEPTION. done is not asserted in that TRANSFER cycle.
- exc_req is ignored in ISSUE, RD_INDIRECT_SHIFT and WITH_SHIFT.
- Arithmetic: all operands are WORD_W bits, with no carry beyond WORD_W. The immediate is zero-extended. Shift amounts above WORD_W are passed through unchanged.

## Timing
- Acceptance happens at the edge where issue_valid && issue_ready. ISSUE is the next cycle.
- Minimum instruction occupancy is 1 cycle (ISSUE). issue_ready is low while busy, so consecutive instructions are separated by at least one IDLE cycle.
- Register-indirect shift with N beats takes 3+N cycles, plus stall cycles while mem_ready is low.
- All outputs except alu_a, alu_b, shifter_shift, trivial_shift, issue_ready and done are registered.
- Reset asserted mid-sequence returns immediately to IDLE with reset values; no done pulse is produced.

## Test plan
- Immediate add: dec_op=ADD, is_imm=1, imm=0x00C, rd_value_a=0x10 -> ISSUE cycle with alu_a=0x10, alu_b=0xC, done=1; back to IDLE next cycle.
- Register-indirect shift: shift_by_reg=1, rd_value_b=0x80 then 0x03 -> saved_base=0x80, shifter_shift=3 in RD_INDIRECT_SHIFT; c_in=c_shifter and alu_b=q_shifter in WITH_SHIFT.
- Three-beat transfer: step=4, q_alu=0x1000, mem_ready low for 2 cycles on beat 2 -> saved_base sequence 0x1000, 0x1004, 0x1008; beats_left 3→2→1; done only on the final ready beat; 5 TRANSFER cycles total.
- Data abort on beat 2 of 4 -> EXCEPTION the next cycle with alu_a={pc,00}, alu_b=4, alu_op=ADD; beats_left=0.
- Simultaneous exc_req and issue_valid in IDLE -> EXCEPTION taken and the instruction not accepted.
- Reset asserted during TRANSFER -> cycle=0, c_in=0, saved_base=0, issue_ready=1 immediately.
